rom_sample_streamer: RTL and testbench
======================================

Name: rom_sample_streamer

Overview:
- Sits between the sample ROM and Audio_Controller, and replaces the free-running address counter in the top level.
- Fetches 16-bit signed PCM samples from a synchronous ROM at a programmable sample rate and buffers them in a small FIFO.
- Drives left/right 32-bit audio words into Audio_Controller using its audio_out_allowed/write_audio_out handshake.
- Supports play/stop, looping, an end-of-clip indication and underrun detection.

Parameters:
- ADDR_W, 17, ROM address width.
- SAMPLE_W, 16, ROM data width (signed two's complement).
- LAST_ADDR, 117531, address of the final sample in the clip.
- TICK_DIV, 2273, clocks per sample period (50 MHz / 2273 ≈ 22 kHz).
- ROM_LATENCY, 2, clocks from rom_address change to valid rom_q.
- FIFO_DEPTH, 4, sample buffer entries (power of two, ≥2).
- OUT_SHIFT, 14, left shift applied to the sign-extended sample.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- play  in  1  level; 1 = run, 0 = stop and flush.
- loop  in  1  sampled at end of clip; 1 = wrap to address 0.
- rom_address  out  ADDR_W  ROM read address.
- rom_q  in  SAMPLE_W  ROM read data.
- audio_out_allowed  in  1  from Audio_Controller.
- write_audio_out  out  1  to Audio_Controller.
- left_channel_audio_out  out  32  output sample.
- right_channel_audio_out  out  32  identical to left.
- busy  out  1  high in FETCH, WAIT or DRAIN.
- done  out  1  one-cycle pulse when the last sample of a non-looped clip is popped.
- underrun  out  1  sticky; cleared on play rising edge or reset.

Behaviour:
- Reset: every output and state register is 0 (FIFO empty, hold register 0, divider 0, FSM in IDLE).
- Rate divider:
  - Counts 0..TICK_DIV-1 while play=1, otherwise held at 0.
  - tick is asserted on the terminal count.
  - The first tick after a play rising edge occurs TICK_DIV clocks later.
- Fetch FSM states: IDLE, FETCH, WAIT, DRAIN.
  - IDLE -> FETCH on play=1; rom_address is set to 0.
  - FETCH: if FIFO not full, present rom_address and go to WAIT; otherwise stay.
  - WAIT: count ROM_LATENCY clocks, then push rom_q. Only one fetch is in flight at a time.
    - If rom_address < LAST_ADDR: increment rom_address, go to FETCH.
    - If rom_address == LAST_ADDR and loop=1: rom_address <= 0, go to FETCH.
    - If rom_address == LAST_ADDR and loop=0: go to DRAIN.
  - DRAIN: no fetches. When the FIFO is empty and the last sample has been popped: pulse done, go to IDLE, hold register <= 0.
  - play=0 in any state: next state IDLE, FIFO flushed, hold register <= 0, rom_address <= 0. An in-flight read is discarded.
- Output path:
  - On tick with FIFO non-empty: pop into the hold register.
  - On tick with FIFO empty while in FETCH or WAIT: set underrun, keep the previous hold value.
  - Output word = sign_extend(hold, 32) << OUT_SHIFT; bits shifted past 31 are discarded. Left and right carry the same value.
  - write_audio_out = audio_out_allowed & play (combinational). The codec re-reads the held sample (zero-order hold).
  - Hold-register update to output word: 1 clock.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A push into a full FIFO cannot occur, because FETCH checks for full.
  - Pop from an empty FIFO never changes the count.
  - A play falling edge in the same cycle as done: done is suppressed.
- Reset mid-operation is asynchronous and returns every register to its reset value immediately.

Optional Feature:
- VOLUME_STREAMER_EN defined:
  - Adds input vol [2:0].
  - The output word is arithmetically right-shifted by vol after the OUT_SHIFT left shift.
  - vol is registered on tick, so volume changes align to sample boundaries.
  - vol=0 gives full scale.
- Macro not defined: no vol port; output as above.

Decomposition:
- Package audio_stream_pkg holds:
  - State enum (IDLE, FETCH, WAIT, DRAIN).
  - AUDIO_W=32.
  - Default SAMPLE_W and ADDR_W constants.
- Sub-module sample_fifo (parameters FIFO_DEPTH and SAMPLE_W):
  - Ports: push, pop, din, dout, full, empty, flush.
  - dout is first-word fall-through.

Test Plan:
- Reset then play=1, TICK_DIV=8, ROM model returns rom_q=address -> hold register takes 0, 1, 2, ... on successive ticks. left_channel_audio_out = 0x4000 after the second tick. No underrun.
- Sample 16'h8000 -> left_channel_audio_out = 32'hE0000000. Sample 16'h7FFF -> 32'h1FFFC000.
- LAST_ADDR=5, loop=0 -> rom_address never exceeds 5. done pulses once, on the tick that pops sample 5. Then IDLE, busy=0, output 0.
- LAST_ADDR=5, loop=1 -> address sequence 0..5, 0..5 continues. done never asserts.
- TICK_DIV=2, ROM_LATENCY=4 (fetch slower than consumption) -> underrun goes to 1 and stays 1. It clears on the next play rising edge.
- play dropped in WAIT with 3 samples buffered -> the next cycle has FIFO empty, output 0, rom_address 0. Re-play restarts from sample 0.

Source files
------------

// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the ROM sample streaming path.
package audio_stream_pkg;

  localparam int AUDIO_W      = 32;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_ADDR_W   = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small first-word fall-through sample buffer between the ROM fetch engine
// and the sample-rate pop. count is exported so the fetch engine can spot
// the final entry of a clip leaving the buffer.
module sample_fifo
  import audio_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [SAMPLE_W-1:0]         din,
  output logic [SAMPLE_W-1:0]         dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops everything in one cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_sample_streamer.sv
// Streams signed PCM samples from a synchronous ROM into Audio_Controller at
// a fixed sample rate, with play/stop, looping, end-of-clip and underrun.
// Optional build macro VOLUME_STREAMER_EN adds a 3-bit vol input that
// attenuates the output by an arithmetic right shift, updated on sample ticks.
//
// state    | meaning
// ST_IDLE  | stopped, or clip finished and waiting for play to be released
// ST_FETCH | address presented; waits here while the FIFO is full
// ST_WAIT  | ROM read in flight, pushes rom_q after ROM_LATENCY clocks
// ST_DRAIN | whole clip fetched, waiting for the last sample to be popped
module rom_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int LAST_ADDR   = 117531,
  parameter int TICK_DIV    = 2273,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int OUT_SHIFT   = 14
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                play,
  input  logic                loop,
`ifdef VOLUME_STREAMER_EN
  input  logic [2:0]          vol,
`endif
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [AUDIO_W-1:0]  left_channel_audio_out,
  output logic [AUDIO_W-1:0]  right_channel_audio_out,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t        state;
  logic [DIV_W-1:0]    div_cnt;
  logic [LAT_W-1:0]    wait_cnt;
  logic                tick;
  logic                play_q;
  logic                play_rise;
  logic                clip_ended;
  logic [SAMPLE_W-1:0] hold;
  logic [AUDIO_W-1:0]  audio_word;
  logic [AUDIO_W-1:0]  sext;
  logic [AUDIO_W-1:0]  scaled;
  logic [AUDIO_W-1:0]  shaped;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic [CNT_W-1:0]    fifo_count;

  assign tick      = play && (div_cnt == DIV_W'(TICK_DIV - 1));
  assign play_rise = play & ~play_q;
  assign fifo_push = play && (state == ST_WAIT) && (wait_cnt == LAT_W'(ROM_LATENCY - 1));
  assign fifo_pop  = tick;

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SAMPLE_W   (SAMPLE_W)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .flush    (~play),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (rom_q),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Sample-rate divider, parked at zero while stopped so restarts are aligned.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      play_q  <= 1'b0;
    end else begin
      play_q <= play;
      if (!play || tick) div_cnt <= '0;
      else               div_cnt <= div_cnt + 1'b1;
    end
  end

  // Fetch engine, hold register, end-of-clip and underrun tracking.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      rom_address <= '0;
      wait_cnt    <= '0;
      hold        <= '0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      clip_ended  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (play_rise)
        underrun <= 1'b0;
      else if (tick && fifo_empty && (state == ST_FETCH || state == ST_WAIT))
        underrun <= 1'b1;

      if (!play) begin
        state       <= ST_IDLE;
        rom_address <= '0;
        wait_cnt    <= '0;
        hold        <= '0;
        clip_ended  <= 1'b0;
      end else begin
        if (tick && !fifo_empty) hold <= fifo_dout;
        case (state)
          ST_IDLE: begin
            // A finished clip stays stopped until play is released.
            if (!clip_ended) begin
              state       <= ST_FETCH;
              rom_address <= '0;
            end
          end
          ST_FETCH: begin
            if (!fifo_full) begin
              state    <= ST_WAIT;
              wait_cnt <= '0;
            end
          end
          ST_WAIT: begin
            if (wait_cnt == LAT_W'(ROM_LATENCY - 1)) begin
              if (rom_address < ADDR_W'(LAST_ADDR)) begin
                rom_address <= rom_address + 1'b1;
                state       <= ST_FETCH;
              end else if (loop) begin
                rom_address <= '0;
                state       <= ST_FETCH;
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_DRAIN: begin
            // The tick popping the final buffered sample ends the clip.
            if (tick && fifo_count == CNT_W'(1)) begin
              done       <= 1'b1;
              state      <= ST_IDLE;
              hold       <= '0;
              clip_ended <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sext   = {{(AUDIO_W - SAMPLE_W){hold[SAMPLE_W-1]}}, hold};
  assign scaled = sext << OUT_SHIFT;

`ifdef VOLUME_STREAMER_EN
  logic [2:0] vol_q;

  // Volume is taken on sample boundaries only, together with the new sample.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)   vol_q <= '0;
    else if (tick) vol_q <= vol;
  end

  assign shaped = AUDIO_W'($signed(scaled) >>> vol_q);
`else
  assign shaped = scaled;
`endif

  // Output word register; forced to zero as soon as play drops.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)    audio_word <= '0;
    else if (!play) audio_word <= '0;
    else            audio_word <= shaped;
  end

  assign left_channel_audio_out  = audio_word;
  assign right_channel_audio_out = audio_word;
  assign write_audio_out         = audio_out_allowed & play;
  assign busy                    = (state != ST_IDLE);

endmodule

// File: tb/tb_rom_sample_streamer.sv
// Directed bench: main instance (TICK_DIV=8, LAST_ADDR=5, ROM_LATENCY=2) for
// streaming, end-of-clip, looping, sign handling and flush; fast instance
// (TICK_DIV=2, ROM_LATENCY=4) for underrun.
module tb_rom_sample_streamer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  vol_zero = 3'd0;

  logic        m_play, m_loop, m_allowed, m_write, m_busy, m_done, m_underrun;
  logic [16:0] m_addr;
  logic [15:0] m_q;
  logic [31:0] m_left, m_right;
  int          m_mode;
  logic [16:0] m_pipe [2];

  logic        f_play, f_loop, f_write, f_busy, f_done, f_underrun;
  logic [16:0] f_addr;
  logic [15:0] f_q;
  logic [31:0] f_left, f_right;
  logic [16:0] f_pipe [4];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt;
  int          done_cyc;
  int          max_addr = 0;
  logic [31:0] exp_q [$];

  always #10 clk = ~clk;

  rom_sample_streamer #(
    .LAST_ADDR (5), .TICK_DIV (8), .ROM_LATENCY (2)
  ) u_main (
    .CLOCK_50                (clk),
    .resetn                  (resetn),
    .play                    (m_play),
    .loop                    (m_loop),
`ifdef VOLUME_STREAMER_EN
    .vol                     (vol_zero),
`endif
    .rom_address             (m_addr),
    .rom_q                   (m_q),
    .audio_out_allowed       (m_allowed),
    .write_audio_out         (m_write),
    .left_channel_audio_out  (m_left),
    .right_channel_audio_out (m_right),
    .busy                    (m_busy),
    .done                    (m_done),
    .underrun                (m_underrun)
  );

  rom_sample_streamer #(
    .LAST_ADDR (5), .TICK_DIV (2), .ROM_LATENCY (4)
  ) u_fast (
    .CLOCK_50                (clk),
    .resetn                  (resetn),
    .play                    (f_play),
    .loop                    (f_loop),
`ifdef VOLUME_STREAMER_EN
    .vol                     (vol_zero),
`endif
    .rom_address             (f_addr),
    .rom_q                   (f_q),
    .audio_out_allowed       (1'b1),
    .write_audio_out         (f_write),
    .left_channel_audio_out  (f_left),
    .right_channel_audio_out (f_right),
    .busy                    (f_busy),
    .done                    (f_done),
    .underrun                (f_underrun)
  );

  function automatic logic [15:0] rom_fn(input int mode, input logic [16:0] a);
    if (mode == 1 && a == 17'd0) return 16'h8000;
    if (mode == 1 && a == 17'd1) return 16'h7FFF;
    return a[15:0];
  endfunction

  // ROM models: registered address pipelines of the configured latency.
  always @(posedge clk) begin
    m_pipe[0] <= m_addr;
    m_pipe[1] <= m_pipe[0];
    f_pipe[0] <= f_addr;
    f_pipe[1] <= f_pipe[0];
    f_pipe[2] <= f_pipe[1];
    f_pipe[3] <= f_pipe[2];
    if (int'(m_addr) > max_addr) max_addr <= int'(m_addr);
  end
  assign m_q = rom_fn(m_mode, m_pipe[1]);
  assign f_q = rom_fn(0, f_pipe[3]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs the main instance; each sample k appears on the output one clock
  // after the k-th tick, i.e. after clock k*t+1 counted from play rising.
  task automatic run_main(input int ncyc, input int t);
    logic [31:0] e;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (m_done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c > t && (c % t) == 1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stream_left", m_left, e);
        chk("stream_right", m_right, e);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    resetn = 1'b0; m_play = 1'b0; m_loop = 1'b0; m_allowed = 1'b0; m_mode = 0;
    f_play = 1'b0; f_loop = 1'b1;
    idle_cycles(3);
    chk("rst_left", m_left, 32'h0);
    chk("rst_addr", 32'(m_addr), 32'h0);
    chk("rst_busy", 32'(m_busy), 32'h0);
    chk("rst_done", 32'(m_done), 32'h0);
    chk("rst_underrun", 32'(m_underrun), 32'h0);
    resetn = 1'b1;
    idle_cycles(2);

    // Non-looped clip: samples 0..4, then done zeroes the hold register.
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(k) << 14);
    exp_q.push_back(32'h0);
    m_play = 1'b1;
    run_main(51, 8);
    chk("clip_done_count", 32'(done_cnt), 32'd1);
    chk("clip_done_cycle", 32'(done_cyc), 32'd48);
    chk("clip_busy_after", 32'(m_busy), 32'h0);
    chk("clip_out_after", m_left, 32'h0);
    chk("clip_no_underrun", 32'(m_underrun), 32'h0);
    chk("clip_max_addr", 32'(max_addr), 32'd5);
    m_play = 1'b0;
    idle_cycles(2);

    // Looped clip: 0..5, 0..5, 0, 1.
    m_loop = 1'b1;
    for (int k = 0; k < 14; k++) exp_q.push_back(32'(k % 6) << 14);
    m_play = 1'b1;
    run_main(113, 8);
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    chk("loop_no_underrun", 32'(m_underrun), 32'h0);
    chk("loop_max_addr", 32'(max_addr), 32'd5);
    m_play = 1'b0;
    idle_cycles(2);

    // Sign extension and flush in WAIT with three buffered samples.
    m_mode = 1;
    exp_q.push_back(32'hE0000000);
    m_play = 1'b1;
    run_main(14, 8);
    chk("preflush_count", 32'(u_main.u_fifo.count), 32'd3);
    chk("preflush_busy", 32'(m_busy), 32'h1);
    m_play = 1'b0;
    idle_cycles(1);
    chk("flush_empty", 32'(u_main.u_fifo.empty), 32'h1);
    chk("flush_out", m_left, 32'h0);
    chk("flush_addr", 32'(m_addr), 32'h0);
    exp_q.push_back(32'hE0000000);
    exp_q.push_back(32'h1FFFC000);
    m_play = 1'b1;
    run_main(17, 8);

    // write_audio_out follows allowed & play.
    m_allowed = 1'b1; #1;
    chk("write_on", 32'(m_write), 32'h1);
    m_play = 1'b0; #1;
    chk("write_off_play", 32'(m_write), 32'h0);
    m_allowed = 1'b0; m_play = 1'b1; #1;
    chk("write_off_allowed", 32'(m_write), 32'h0);
    m_play = 1'b0;
    m_mode = 0;
    idle_cycles(2);

    // Underrun: fetch slower than consumption.
    f_play = 1'b1;
    idle_cycles(1);
    chk("ur_clear_start", 32'(f_underrun), 32'h0);
    idle_cycles(4);
    chk("ur_set", 32'(f_underrun), 32'h1);
    idle_cycles(35);
    chk("ur_sticky_run", 32'(f_underrun), 32'h1);
    f_play = 1'b0;
    idle_cycles(3);
    chk("ur_sticky_stop", 32'(f_underrun), 32'h1);
    f_play = 1'b1;
    idle_cycles(1);
    chk("ur_clear_replay", 32'(f_underrun), 32'h0);
    f_play = 1'b0;
    idle_cycles(2);

    // Asynchronous reset in the middle of streaming.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4000);
    m_play = 1'b1;
    run_main(20, 8);
    chk("premid_busy", 32'(m_busy), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_left", m_left, 32'h0);
    chk("midrst_addr", 32'(m_addr), 32'h0);
    chk("midrst_busy", 32'(m_busy), 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    m_play = 1'b0;
    idle_cycles(1);
    resetn = 1'b1;
    idle_cycles(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
